pattern_sequencer: RTL and testbench
====================================

PATTERN_SEQUENCER -- requirements
Module: pattern_sequencer

Interface
REQ-001 SHALL have parameter NX, default 6, meaning input features per pattern.
REQ-002 SHALL have parameter BITS, default 32, meaning fixed-point word width.
REQ-003 SHALL have parameter NTRAIN, default 64, meaning training patterns per epoch (>=1).
REQ-004 SHALL have parameter NVAL, default 16, meaning validation patterns per epoch (>=1).
REQ-005 SHALL have parameter EPOCHS, default 10, meaning epochs to run (>=1).
REQ-006 SHALL have parameter LR_INIT, default 32'h00000100, meaning initial learning rate.
REQ-007 SHALL have parameter LR_STEP, default 4, meaning epochs between learning-rate halvings.
REQ-008 SHALL have parameter LR_MIN, default 32'h00000001, meaning learning-rate floor.
REQ-009 SHALL have ports clk in 1 (the single clock) and rst in 1 (synchronous, active-high reset).
REQ-010 SHALL have port start in 1, meaning begin run (pulse).
REQ-011 SHALL have ports x out [NX-1:0][BITS-1:0], meaning current pattern features; y out BITS, meaning current pattern label; lr out BITS, meaning current learning rate.
REQ-012 SHALL have ports TR out 1, meaning train request; VL out 1, meaning validate request; END out 1, meaning run complete.
REQ-013 SHALL have ports S_Train in 1, meaning training pattern complete; S_Error in 1, meaning validation pattern complete; Error in BITS, meaning mismatch flag, with only bit 0 used.
REQ-014 SHALL have ports err_count out $clog2(NVAL+1), meaning errors in the last completed validation pass; epoch out $clog2(EPOCHS+1), meaning completed epochs; busy out 1, meaning run in progress.

Function
REQ-015 SHALL implement FSM states IDLE, FETCH, LOAD, TRAIN, VALID, DONE.
REQ-016 IDLE: start=1 SHALL clear idx, phase (train), epoch, and accumulator; load lr=LR_INIT; go to FETCH.
REQ-017 FETCH SHALL present the ROM address (idx for train, NTRAIN+idx for validation); next state LOAD.
REQ-018 LOAD SHALL register ROM data into x and y; next state TRAIN or VALID per phase.
REQ-019 TR SHALL be 1 exactly while in TRAIN and VL SHALL be 1 exactly while in VALID, both registered; first TR SHALL appear 3 cycles after start is sampled.
REQ-020 x, y, and lr SHALL remain stable for the whole time TR or VL is high.
REQ-021 TRAIN with S_Train=1: idx==NTRAIN-1 SHALL set idx=0 and phase=validation, otherwise idx++; then FETCH.
REQ-022 VALID with S_Error=1: accumulator SHALL add Error[0] (saturating at NVAL).
REQ-023 Last validation pattern (idx==NVAL-1) SHALL: copy the final accumulator (including this pattern) to err_count, clear the accumulator, increment epoch, and set idx=0.
REQ-024 After that epoch update: epoch==EPOCHS SHALL go to DONE, otherwise phase=train and FETCH.
REQ-025 At each epoch increment where the new epoch % LR_STEP==0, lr SHALL become max(lr>>>1, LR_MIN) as a signed arithmetic shift.
REQ-026 DONE SHALL hold END=1, busy=0, and err_count/epoch; start=1 SHALL restart as from IDLE.
REQ-027 busy SHALL be 1 in FETCH, LOAD, TRAIN, and VALID.
REQ-028 start SHALL be ignored while busy.
REQ-029 S_Train SHALL be ignored outside TRAIN, and S_Error outside VALID.
REQ-030 An S_Train/S_Error held high for several cycles SHALL count once, because the FSM leaves the state.
REQ-031 Simultaneous S_Train and S_Error SHALL be acted on only per the current state.

Reset
REQ-032 rst=1 SHALL override all inputs including start.
REQ-033 Reset values SHALL be: state IDLE; TR=VL=END=busy=0; x=0; y=0; lr=LR_INIT; err_count=0; epoch=0; idx=0; accumulator=0.
REQ-034 rst asserted mid-run SHALL abort within the same edge, with TR/VL low the next cycle.
REQ-035 ROM contents SHALL be unaffected by reset.

Structure
REQ-036 A shared package SHALL hold the FSM state enum and the default BITS/NX constants.
REQ-037 The module SHALL contain one sub-module, pattern_rom: NTRAIN+NVAL entries of {y, x}, one-cycle registered read, initialised via hex file at elaboration.
REQ-038 Counters SHALL be sized by $clog2 of their parameter bounds.

Verification (NTRAIN=4, NVAL=2, EPOCHS=2, LR_STEP=1, LR_INIT=32'h100)
REQ-039 Start, with S_Train returned 2 cycles after each TR -> 4 TR pulses carrying ROM entries 0..3, then VL with entry 4.
REQ-040 Validation Error sequence 1,0 in epoch 0 and 1,1 in epoch 1 -> err_count=1 after epoch 0, then 2; epoch=2; END=1.
REQ-041 lr=32'h100 in epoch 0 and 32'h80 in epoch 1; LR_INIT=32'h1 with LR_MIN=32'h1 -> lr stays 32'h1.
REQ-042 S_Error pulsed during TRAIN, and S_Train held high 5 cycles -> no extra count; idx advances by exactly 1.
REQ-043 rst during the 3rd TR -> next cycle TR=0, state IDLE, outputs at reset values; a new start replays from entry 0.
REQ-044 start during VALID -> ignored; start in DONE -> new run, epoch=0, lr=32'h100.

Source files
------------

// File: rtl/pattern_sequencer_pkg.sv
// Shared types and default widths for the pattern sequencer and its ROM.
package pattern_sequencer_pkg;

  localparam int DEFAULT_BITS = 32;
  localparam int DEFAULT_NX   = 6;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    TRAIN,
    VALID,
    DONE
  } state_e;

  typedef enum logic {
    PH_TRAIN,
    PH_VALID
  } phase_e;

endpackage

// File: rtl/pattern_sequencer_rom.sv
// Pattern store: DEPTH entries of {y, x} with a one-cycle registered read.
// Entry e holds feature j = (e+1)*256 + j and label = 0x5A00 + e.
module pattern_rom
  import pattern_sequencer_pkg::*;
#(
  parameter int NX    = DEFAULT_NX,
  parameter int BITS  = DEFAULT_BITS,
  parameter int DEPTH = 80,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic [AW-1:0]             addr_i,
  output logic [NX-1:0][BITS-1:0]   x_o,
  output logic [BITS-1:0]           y_o
);

  logic [NX-1:0][BITS-1:0] x_q;
  logic [BITS-1:0]         y_q;

  function automatic logic [BITS-1:0] feature_word(input int unsigned entry,
                                                   input int unsigned feat);
    return BITS'(entry * 32'd256 + 32'd256 + feat);
  endfunction

  function automatic logic [BITS-1:0] label_word(input int unsigned entry);
    return BITS'(32'h0000_5A00 + entry);
  endfunction

  // Registered read of the constant pattern table.
  // NOTE: the read register carries no reset; ROM contents and its read
  // port are independent of rst and reset would only cost routing.
  always_ff @(posedge clk) begin
    for (int j = 0; j < NX; j++) begin
      x_q[j] <= feature_word(int'(addr_i), j);
    end
    y_q <= label_word(int'(addr_i));
  end

  assign x_o = x_q;
  assign y_o = y_q;

endmodule

// File: rtl/pattern_sequencer.sv
// Epoch/pattern sequencer: streams training then validation patterns to an
// external learner, counts validation errors and decays the learning rate.
module pattern_sequencer
  import pattern_sequencer_pkg::*;
#(
  parameter int              NX      = DEFAULT_NX,
  parameter int              BITS    = DEFAULT_BITS,
  parameter int              NTRAIN  = 64,
  parameter int              NVAL    = 16,
  parameter int              EPOCHS  = 10,
  parameter logic [BITS-1:0] LR_INIT = BITS'(32'h0000_0100),
  parameter int              LR_STEP = 4,
  parameter logic [BITS-1:0] LR_MIN  = BITS'(32'h0000_0001)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  output logic [NX-1:0][BITS-1:0]          x,
  output logic [BITS-1:0]                  y,
  output logic [BITS-1:0]                  lr,
  output logic                             TR,
  output logic                             VL,
  output logic                             END,
  input  logic                             S_Train,
  input  logic                             S_Error,
  input  logic [BITS-1:0]                  Error,
  output logic [$clog2(NVAL+1)-1:0]        err_count,
  output logic [$clog2(EPOCHS+1)-1:0]      epoch,
  output logic                             busy
);

  localparam int DEPTH = NTRAIN + NVAL;
  localparam int AW    = $clog2(DEPTH);
  localparam int IMAX  = (NTRAIN > NVAL) ? NTRAIN : NVAL;
  localparam int IW    = $clog2(IMAX + 1);
  localparam int CW    = $clog2(NVAL + 1);
  localparam int EW    = $clog2(EPOCHS + 1);

  state_e                  state_q, state_d;
  phase_e                  phase_q, phase_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [CW-1:0]           acc_q, acc_d, acc_sum;
  logic [CW-1:0]           err_q, err_d;
  logic [EW-1:0]           epoch_q, epoch_d;
  logic [BITS-1:0]         lr_q, lr_d, lr_floor;
  logic signed [BITS-1:0]  lr_half;
  logic                    tr_q, vl_q, end_q, busy_q, load_xy;
  logic [NX-1:0][BITS-1:0] x_q, rom_x;
  logic [BITS-1:0]         y_q, rom_y;
  logic [AW-1:0]           rom_addr;
  logic                    unused_error;

  // Only bit 0 of Error carries the mismatch flag.
  assign unused_error = ^Error[BITS-1:1];

  // Validation patterns sit directly after the training block.
  assign rom_addr = (phase_q == PH_VALID) ? AW'(NTRAIN + int'(idx_q)) : AW'(idx_q);

  pattern_rom #(
    .NX    (NX),
    .BITS  (BITS),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_rom (
    .clk    (clk),
    .addr_i (rom_addr),
    .x_o    (rom_x),
    .y_o    (rom_y)
  );

  // Halve as a signed value, never dropping below the floor.
  assign lr_half  = $signed(lr_q) >>> 1;
  assign lr_floor = (lr_half > $signed(LR_MIN)) ? lr_half : LR_MIN;

  // Next-state and bookkeeping decisions for the run.
  // NOTE: every variable gets its hold value first so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    err_d   = err_q;
    epoch_d = epoch_q;
    lr_d    = lr_q;
    load_xy = 1'b0;
    acc_sum = (acc_q < CW'(NVAL)) ? acc_q + CW'(Error[0]) : acc_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = FETCH;
          phase_d = PH_TRAIN;
          idx_d   = '0;
          epoch_d = '0;
          acc_d   = '0;
          lr_d    = LR_INIT;
        end
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        load_xy = 1'b1;
        state_d = (phase_q == PH_VALID) ? VALID : TRAIN;
      end
      TRAIN: begin
        if (S_Train) begin
          state_d = FETCH;
          if (idx_q == IW'(NTRAIN - 1)) begin
            idx_d   = '0;
            phase_d = PH_VALID;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      VALID: begin
        if (S_Error) begin
          if (idx_q == IW'(NVAL - 1)) begin
            err_d   = acc_sum;
            acc_d   = '0;
            idx_d   = '0;
            epoch_d = epoch_q + EW'(1);
            if ((int'(epoch_d) % LR_STEP) == 0) begin
              lr_d = lr_floor;
            end
            if (epoch_d == EW'(EPOCHS)) begin
              state_d = DONE;
            end else begin
              phase_d = PH_TRAIN;
              state_d = FETCH;
            end
          end else begin
            acc_d   = acc_sum;
            idx_d   = idx_q + IW'(1);
            state_d = FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; rst overrides everything on the same edge.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      phase_q <= PH_TRAIN;
      idx_q   <= '0;
      acc_q   <= '0;
      err_q   <= '0;
      epoch_q <= '0;
      lr_q    <= LR_INIT;
      tr_q    <= 1'b0;
      vl_q    <= 1'b0;
      end_q   <= 1'b0;
      busy_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
      epoch_q <= epoch_d;
      lr_q    <= lr_d;
      tr_q    <= (state_d == TRAIN);
      vl_q    <= (state_d == VALID);
      end_q   <= (state_d == DONE);
      busy_q  <= (state_d inside {FETCH, LOAD, TRAIN, VALID});
      if (load_xy) begin
        x_q <= rom_x;
        y_q <= rom_y;
      end
    end
  end

  assign x         = x_q;
  assign y         = y_q;
  assign lr        = lr_q;
  assign TR        = tr_q;
  assign VL        = vl_q;
  assign END       = end_q;
  assign busy      = busy_q;
  assign err_count = err_q;
  assign epoch     = epoch_q;

endmodule

// File: tb/tb_pattern_sequencer.sv
// Bench for pattern_sequencer: a request-level model predicts which pattern,
// learning rate, epoch and error count each TR/VL request must carry.
module tb_pattern_sequencer;

  localparam int          NX      = 3;
  localparam int          BITS    = 32;
  localparam int          NTRAIN  = 4;
  localparam int          NVAL    = 2;
  localparam int          EPOCHS  = 2;
  localparam int          LR_STEP = 1;
  localparam logic [31:0] LR_INIT = 32'h100;
  localparam logic [31:0] LR_MIN  = 32'h1;
  localparam int          PER     = NTRAIN + NVAL;
  localparam int          TOTAL   = PER * EPOCHS;

  logic clk = 1'b0;
  logic rst, start, S_Train, S_Error;
  logic [BITS-1:0] Error;

  logic [NX-1:0][BITS-1:0] x, x_f;
  logic [BITS-1:0] y, lr, y_f, lr_f;
  logic TR, VL, END, busy, TR_f, VL_f, END_f, busy_f;
  logic [$clog2(NVAL+1)-1:0]   err_count, err_count_f;
  logic [$clog2(EPOCHS+1)-1:0] epoch, epoch_f;

  int vectors    = 0;
  int miscompares = 0;

  // Validation mismatch flags returned per epoch and pattern.
  int err_tab [EPOCHS][NVAL] = '{'{1, 0}, '{1, 1}};

  always #5 clk = ~clk;

  pattern_sequencer #(
    .NX(NX), .BITS(BITS), .NTRAIN(NTRAIN), .NVAL(NVAL), .EPOCHS(EPOCHS),
    .LR_INIT(LR_INIT), .LR_STEP(LR_STEP), .LR_MIN(LR_MIN)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .x(x), .y(y), .lr(lr),
    .TR(TR), .VL(VL), .END(END), .S_Train(S_Train), .S_Error(S_Error),
    .Error(Error), .err_count(err_count), .epoch(epoch), .busy(busy)
  );

  // Same sequencing with a learning rate that already sits on the floor.
  pattern_sequencer #(
    .NX(NX), .BITS(BITS), .NTRAIN(NTRAIN), .NVAL(NVAL), .EPOCHS(EPOCHS),
    .LR_INIT(32'h1), .LR_STEP(LR_STEP), .LR_MIN(32'h1)
  ) dut_floor (
    .clk(clk), .rst(rst), .start(start), .x(x_f), .y(y_f), .lr(lr_f),
    .TR(TR_f), .VL(VL_f), .END(END_f), .S_Train(S_Train), .S_Error(S_Error),
    .Error(Error), .err_count(err_count_f), .epoch(epoch_f), .busy(busy_f)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---- model -------------------------------------------------------------
  function automatic logic [31:0] exp_feature(input int e, input int j);
    return 32'((e + 1) * 256 + j);
  endfunction

  function automatic logic [31:0] exp_label(input int e);
    return 32'(32'h5A00 + e);
  endfunction

  // Learning rate during epoch ep: halved once per completed LR_STEP epochs.
  function automatic logic [31:0] exp_lr(input int ep);
    logic [31:0] v;
    v = LR_INIT >> (ep / LR_STEP);
    return (v < LR_MIN) ? LR_MIN : v;
  endfunction

  function automatic int exp_errs(input int ep);
    int s = 0;
    for (int i = 0; i < NVAL; i++) s += err_tab[ep][i];
    return s;
  endfunction

  // ---- compare process ---------------------------------------------------
  int                      req_n    = 0;
  logic                    prev_req = 1'b0;
  logic                    cap_tr;
  logic [NX-1:0][BITS-1:0] cap_x;
  logic [BITS-1:0]         cap_y, cap_lr;

  always @(negedge clk) begin
    int ep, k;
    check("floor_lr", lr_f, 32'h1);
    check("tr_vl_exclusive", {31'b0, TR & VL}, 32'd0);
    if (!rst && (TR || VL)) begin
      if (!prev_req) begin
        ep = req_n / PER;
        k  = req_n % PER;
        check("req_kind_tr", {31'b0, TR}, (k < NTRAIN) ? 32'd1 : 32'd0);
        for (int j = 0; j < NX; j++) check("req_x", x[j], exp_feature(k, j));
        check("req_y", y, exp_label(k));
        check("req_lr", lr, exp_lr(ep));
        check("req_epoch", 32'(epoch), 32'(ep));
        if (ep > 0) check("req_err_count", 32'(err_count), 32'(exp_errs(ep - 1)));
        cap_tr = TR;
        cap_x  = x;
        cap_y  = y;
        cap_lr = lr;
        req_n++;
      end else begin
        check("hold_kind", {31'b0, TR}, {31'b0, cap_tr});
        for (int j = 0; j < NX; j++) check("hold_x", x[j], cap_x[j]);
        check("hold_y", y, cap_y);
        check("hold_lr", lr, cap_lr);
      end
    end
    prev_req = TR | VL;
    if (!busy) req_n = 0;
  end

  // ---- stimulus helpers --------------------------------------------------
  task automatic wait_req();
    for (int i = 0; i < 40 && !(TR || VL); i++) @(negedge clk);
    check("req_seen", {31'b0, TR | VL}, 32'd1);
  endtask

  // Answer the visible request: S_Train two cycles after TR, or S_Error
  // with this pattern's flag. noise adds a stray S_Error during TRAIN;
  // start_in_valid pulses start while VALID.
  task automatic serve(input int ep, input int k, input bit noise, input bit start_in_valid);
    if (TR) begin
      if (noise) begin
        S_Error = 1'b1;
        Error   = 32'd1;
      end
      @(negedge clk);
      S_Train = 1'b1;
      @(negedge clk);
      S_Train = 1'b0;
      S_Error = 1'b0;
      Error   = 32'd0;
    end else begin
      if (start_in_valid) start = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      Error   = 32'(err_tab[ep][k - NTRAIN]);
      S_Error = 1'b1;
      @(negedge clk);
      S_Error = 1'b0;
      Error   = 32'd0;
    end
  endtask

  task automatic run_full(input int n0, input bit noise, input bit start_in_valid);
    logic [31:0] lr_at [TOTAL];
    logic [31:0] err_at [TOTAL];
    for (int n = n0; n < TOTAL; n++) begin
      wait_req();
      lr_at[n]  = lr;
      err_at[n] = 32'(err_count);
      serve(n / PER, n % PER, noise, start_in_valid);
    end
    for (int i = 0; i < 20 && !END; i++) @(negedge clk);
    check("lr_epoch0", lr_at[NTRAIN], 32'h100);
    check("lr_epoch1", lr_at[PER], 32'h80);
    check("err_after_epoch0", err_at[PER], 32'd1);
    check("end_flag", {31'b0, END}, 32'd1);
    check("end_busy", {31'b0, busy}, 32'd0);
    check("end_epoch", 32'(epoch), 32'd2);
    check("end_err_count", 32'(err_count), 32'd2);
    check("end_tr", {31'b0, TR}, 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_tr"}, {31'b0, TR}, 32'd0);
    check({tag, "_vl"}, {31'b0, VL}, 32'd0);
    check({tag, "_end"}, {31'b0, END}, 32'd0);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_x0"}, x[0], 32'd0);
    check({tag, "_y"}, y, 32'd0);
    check({tag, "_lr"}, lr, 32'h100);
    check({tag, "_err"}, 32'(err_count), 32'd0);
    check({tag, "_epoch"}, 32'(epoch), 32'd0);
  endtask

  // ---- main sequence -----------------------------------------------------
  initial begin
    int tr_hi;
    rst = 1'b1; start = 1'b0; S_Train = 1'b0; S_Error = 1'b0; Error = '0;
    repeat (3) @(negedge clk);
    start = 1'b1;                       // ignored under reset
    @(negedge clk);
    check_reset_state("reset");
    start = 1'b0;
    rst   = 1'b0;

    // Run A: start latency, stray S_Error during TRAIN, full two epochs.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("lat_c1_tr", {31'b0, TR}, 32'd0);
    check("lat_c1_busy", {31'b0, busy}, 32'd1);
    @(negedge clk);
    check("lat_c2_tr", {31'b0, TR}, 32'd0);
    @(negedge clk);
    check("lat_c3_tr", {31'b0, TR}, 32'd1);
    check("lat_c3_x1", x[1], 32'h101);
    check("lat_c3_y", y, 32'h5A00);
    check("lat_c3_lr", lr, 32'h100);
    run_full(0, 1'b1, 1'b0);

    // Run B: restart from DONE with S_Train held over five edges,
    // plus start pulses while VALID.
    @(negedge clk);
    start = 1'b1;
    S_Train = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("restart_epoch", 32'(epoch), 32'd0);
    check("restart_lr", lr, 32'h100);
    check("restart_busy", {31'b0, busy}, 32'd1);
    tr_hi = 0;
    for (int i = 0; i < 4; i++) begin
      if (TR) tr_hi++;
      @(negedge clk);
    end
    S_Train = 1'b0;
    check("held_strain_tr_cycles", 32'(tr_hi), 32'd1);
    run_full(1, 1'b0, 1'b1);

    // Run C: reset during the third TR.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 2; n++) begin
      wait_req();
      serve(0, n, 1'b0, 1'b0);
    end
    wait_req();
    check("third_tr_present", {31'b0, TR}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_state("abort");
    rst = 1'b0;

    // Run D: fresh start replays from entry 0.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_full(0, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
